// File: rtl/arb_pkg.sv
// Shared types and widths for the arbiter byte-to-word packer.
package arb_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;
  localparam int LEN_W      = 3;
  localparam int WORD_W     = BYTE_W * WORD_BYTES;

  // One queued word: number of valid bytes plus little-endian data.
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [WORD_W-1:0] data;
  } word_entry_t;

  // Assembly state: EMPTY means no partial bytes are held.
  typedef enum logic {
    EMPTY,
    FILL
  } asm_state_t;

endpackage

// File: rtl/arb_word_packer_if.sv
// Byte input, word output handshake and drop status of the word packer.
interface arb_word_packer_if;

  logic [arb_pkg::BYTE_W-1:0] din;
  logic                       din_valid;
  logic                       flush;
  logic [arb_pkg::WORD_W-1:0] word_out;
  logic [arb_pkg::LEN_W-1:0]  word_len;
  logic                       word_valid;
  logic                       word_ready;
  logic                       overflow;
  logic [7:0]                 drop_cnt;

  // The packer itself.
  modport slave (
    input  din, din_valid, flush, word_ready,
    output word_out, word_len, word_valid, overflow, drop_cnt
  );

  // The producer/consumer around the packer.
  modport master (
    output din, din_valid, flush, word_ready,
    input  word_out, word_len, word_valid, overflow, drop_cnt
  );

endinterface

// File: rtl/word_queue.sv
// Small synchronous FIFO of word entries. A push into a full queue only
// lands when a pop frees the head slot on the same edge; otherwise it is
// ignored and the stored entries are left untouched.
module word_queue
  import arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  word_entry_t push_data,
  input  logic        pop,
  output word_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int PW = AW + 1;

  word_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr - rd_ptr) == PW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage and pointers; reset clears contents so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/arb_word_packer.sv
// Packs the arbiter's byte stream into 32-bit little-endian words, flushing
// partial words on idle timeout or request, and queues them for a consumer.
// The byte source cannot be stalled, so words that find the queue full are
// dropped and counted.
module arb_word_packer
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int DEPTH   = 2
) (
  input logic              clk,
  input logic              rst_n,
  arb_word_packer_if.slave bus
);

  localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  asm_state_t        state;
  logic [WORD_W-1:0] asm_data;
  logic [1:0]        asm_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [WORD_W-1:0] next_data;
  logic [LEN_W-1:0]  next_len;
  logic              timeout;
  logic              push;
  word_entry_t       push_entry;
  word_entry_t       head;
  logic              q_full;
  logic              q_empty;
  logic              drop;
  logic              overflow;
  logic [7:0]        drop_cnt;

  // Merge the incoming byte into its lane and decide whether a word leaves.
  always_comb begin
    next_data = asm_data;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (bus.din_valid && (asm_cnt == 2'(i))) begin
        next_data[i*BYTE_W +: BYTE_W] = bus.din;
      end
    end
    next_len        = LEN_W'(asm_cnt) + LEN_W'(bus.din_valid);
    timeout         = (state == FILL) && !bus.din_valid &&
                      (idle_cnt == IDLE_W'(TIMEOUT - 1));
    push            = (next_len == LEN_W'(WORD_BYTES)) ||
                      (bus.flush && (next_len != '0)) || timeout;
    push_entry.len  = next_len;
    push_entry.data = next_data;
  end

  // Assembly FSM; unused lanes are kept zero so flushed words need no masking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      asm_data <= '0;
      asm_cnt  <= '0;
      idle_cnt <= '0;
    end else if (push) begin
      state    <= EMPTY;
      asm_data <= '0;
      asm_cnt  <= '0;
      idle_cnt <= '0;
    end else if (bus.din_valid) begin
      state    <= FILL;
      asm_data <= next_data;
      asm_cnt  <= asm_cnt + 2'd1;
      idle_cnt <= '0;
    end else if (state == FILL) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end else begin
      idle_cnt <= '0;
    end
  end

  word_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_entry),
    .pop      (bus.word_ready),
    .head     (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  // A push is lost only when the queue is full and nothing pops this edge.
  assign drop = push && q_full && !(bus.word_ready && !q_empty);

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  assign bus.word_out   = head.data;
  assign bus.word_len   = head.len;
  assign bus.word_valid = !q_empty;
  assign bus.overflow   = overflow;
  assign bus.drop_cnt   = drop_cnt;

endmodule

// File: tb/tb_arb_word_packer.sv
// Self-checking bench for arb_word_packer: a scoreboard of expected words is
// filled as bytes are driven and drained by a monitor on every pop.
module tb_arb_word_packer;
  import arb_pkg::*;

  localparam int TIMEOUT = 8;
  localparam int DEPTH   = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [34:0] expq [$];
  logic [34:0] exp_word;

  arb_word_packer_if bus ();

  arb_word_packer #(
    .TIMEOUT(TIMEOUT),
    .DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every handshake pops and compares the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("[TB] FAIL scoreboard_unexpected: got len=%0d data=%08h, required no word",
                 bus.word_len, bus.word_out);
      end else begin
        exp_word = expq.pop_front();
        if ({bus.word_len, bus.word_out} !== exp_word) begin
          bad++;
          $display("[TB] FAIL scoreboard_word: got len=%0d data=%08h, required len=%0d data=%08h",
                   bus.word_len, bus.word_out, exp_word[34:32], exp_word[31:0]);
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic f);
    bus.din       = b;
    bus.din_valid = 1'b1;
    bus.flush     = f;
    tick();
    bus.din_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.flush      = 1'b0;
    bus.word_ready = 1'b0;
    #12;
    total++;
    if (bus.word_valid !== 1'b0 || bus.word_len !== 3'd0) begin
      bad++;
      $display("[TB] FAIL reset_valid_len: got valid=%b len=%0d, required 0/0",
               bus.word_valid, bus.word_len);
    end
    total++;
    if (bus.word_out !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_word_out: got %08h, required 00000000", bus.word_out);
    end
    total++;
    if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      bad++;
      $display("[TB] FAIL reset_drop: got overflow=%b drop_cnt=%0d, required 0/0",
               bus.overflow, bus.drop_cnt);
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_word();
    bus.word_ready = 1'b1;
    expq.push_back({3'd4, 32'h0C093857});
    send(8'd87, 1'b0);
    send(8'd56, 1'b0);
    send(8'd9, 1'b0);
    send(8'd12, 1'b0);
    total++;
    if (bus.word_valid !== 1'b1 || bus.word_len !== 3'd4) begin
      bad++;
      $display("[TB] FAIL full_word_latency: got valid=%b len=%0d, required 1/4",
               bus.word_valid, bus.word_len);
    end
    tick();
    total++;
    if (bus.word_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL full_word_one_cycle: got valid=%b, required 0", bus.word_valid);
    end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("[TB] FAIL full_word_drain: got pending=%0d, required 0", expq.size());
    end
  endtask

  task automatic test_timeout();
    bus.word_ready = 1'b1;
    expq.push_back({3'd1, 32'h00000055});
    send(8'd85, 1'b0);
    for (int k = 0; k < TIMEOUT; k++) begin
      total++;
      if (bus.word_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL timeout_early: edge E+%0d got valid=%b, required 0", k, bus.word_valid);
      end
      if (k < TIMEOUT - 1) tick();
    end
    tick();
    total++;
    if (bus.word_valid !== 1'b1 || bus.word_len !== 3'd1) begin
      bad++;
      $display("[TB] FAIL timeout_push: at E+%0d got valid=%b len=%0d, required 1/1",
               TIMEOUT, bus.word_valid, bus.word_len);
    end
    tick();
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("[TB] FAIL timeout_drain: got pending=%0d, required 0", expq.size());
    end
  endtask

  task automatic test_flush_with_byte();
    logic seen = 1'b0;
    bus.word_ready = 1'b1;
    expq.push_back({3'd3, 32'h00073381});
    send(8'd129, 1'b0);
    send(8'd51, 1'b0);
    send(8'd7, 1'b1);
    total++;
    if (bus.word_valid !== 1'b1 || bus.word_len !== 3'd3) begin
      bad++;
      $display("[TB] FAIL flush_byte_push: got valid=%b len=%0d, required 1/3",
               bus.word_valid, bus.word_len);
    end
    tick();
    for (int k = 0; k < TIMEOUT + 3; k++) begin
      if (bus.word_valid === 1'b1) seen = 1'b1;
      tick();
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_byte_second: got extra word=%b, required 0", seen);
    end
  endtask

  task automatic test_flush_empty();
    bus.word_ready = 1'b1;
    bus.flush      = 1'b1;
    tick();
    bus.flush      = 1'b0;
    total++;
    if (bus.word_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_empty: got valid=%b, required 0", bus.word_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w = '0;
    logic [7:0]  b;
    bus.word_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(0, 255));
      w[8*(i%4) +: 8] = b;
      if (i % 4 == 3) expq.push_back({3'd4, w});
      send(b, (i == 11) ? 1'b1 : 1'b0);
    end
    wait_drain();
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("[TB] FAIL back_to_back_drain: got pending=%0d, required 0", expq.size());
    end
    for (int k = 0; k < TIMEOUT + 2; k++) tick();
    total++;
    if (bus.word_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL back_to_back_extra: got valid=%b, required 0", bus.word_valid);
    end
  endtask

  task automatic test_overflow();
    bus.word_ready = 1'b0;
    expq.push_back({3'd4, 32'h04030201});
    expq.push_back({3'd4, 32'h08070605});
    for (int i = 1; i <= 12; i++) begin
      send(8'(i), 1'b0);
    end
    total++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 32'h04030201 || bus.word_len !== 3'd4) begin
      bad++;
      $display("[TB] FAIL overflow_head: got valid=%b len=%0d data=%08h, required 1/4/04030201",
               bus.word_valid, bus.word_len, bus.word_out);
    end
    total++;
    if (bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd1) begin
      bad++;
      $display("[TB] FAIL overflow_flag: got overflow=%b drop_cnt=%0d, required 1/1",
               bus.overflow, bus.drop_cnt);
    end
    bus.word_ready = 1'b1;
    wait_drain();
    tick();
    total++;
    if (expq.size() != 0 || bus.word_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL overflow_pop: got pending=%0d valid=%b, required 0/0",
               expq.size(), bus.word_valid);
    end
    total++;
    if (bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd1) begin
      bad++;
      $display("[TB] FAIL overflow_sticky: got overflow=%b drop_cnt=%0d, required 1/1",
               bus.overflow, bus.drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bus.word_ready = 1'b0;
    expq.push_back({3'd4, 32'hF4F3F2F1});
    send(8'hF1, 1'b0);
    send(8'hF2, 1'b0);
    send(8'hF3, 1'b0);
    send(8'hF4, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    expq.delete();
    total++;
    if (bus.word_valid !== 1'b0 || bus.word_out !== 32'h0 || bus.word_len !== 3'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid_word: got valid=%b len=%0d data=%08h, required 0/0/00000000",
               bus.word_valid, bus.word_len, bus.word_out);
    end
    total++;
    if (bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0) begin
      bad++;
      $display("[TB] FAIL reset_mid_drop: got overflow=%b drop_cnt=%0d, required 0/0",
               bus.overflow, bus.drop_cnt);
    end
    tick();
    #2 rst_n = 1'b1;
    tick();
    bus.word_ready = 1'b1;
    expq.push_back({3'd4, 32'hDDCCBBAA});
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    send(8'hDD, 1'b0);
    total++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 32'hDDCCBBAA) begin
      bad++;
      $display("[TB] FAIL reset_mid_fresh: got valid=%b data=%08h, required 1/DDCCBBAA",
               bus.word_valid, bus.word_out);
    end
    wait_drain();
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("[TB] FAIL reset_mid_drain: got pending=%0d, required 0", expq.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_timeout();
    test_flush_with_byte();
    test_flush_empty();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arb_word_packer.md
# arb_word_packer

Downstream consumer of the round-robin FIFO arbiter's byte stream. It collects the arbiter's `dout`/`valid` bytes into 32-bit words, little-endian by arrival. Partial words are flushed on an idle timeout or an explicit flush. Completed words are buffered in a small output queue with a ready/valid handshake. The arbiter cannot be back-pressured, so queue overflow drops words and is reported rather than stalled.

## Interface
- `TIMEOUT`, default 8: idle cycles before a partial word is flushed; must be ≥ 1.
- `DEPTH`, default 2: output queue entries; power of two, ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `din` in 8: byte from the arbiter's `dout`.
- `din_valid` in 1: byte qualifier, from the arbiter's `valid`.
- `flush` in 1: force a partial word out.
- `word_out` out 32: queue head data.
- `word_len` out 3: number of valid bytes in `word_out`, 1..4.
- `word_valid` out 1: queue not empty.
- `word_ready` in 1: consumer accepts the head.
- `overflow` out 1: sticky flag, set when any word has been dropped.
- `drop_cnt` out 8: count of dropped words, saturating at 255.

## Operation
- **Assembly register:** `asm_data[31:0]` and `asm_cnt` (0..3).
  - FSM state EMPTY when `asm_cnt==0`, otherwise state FILL.
- **Accepting a byte:** on a `din_valid` edge, `din` is written to lane `asm_cnt` (bits `[8*asm_cnt+7 : 8*asm_cnt]`) and `asm_cnt` is incremented.
  - When the 4th byte arrives, push `{len=4, data}` and return to EMPTY in the same edge.
- **Idle counter:**
  - Cleared on any `din_valid`, and while in EMPTY.
  - Increments each cycle the block is in FILL with `din_valid` low.
  - An edge where the counter equals `TIMEOUT-1` and it would increment is a timeout.
- **Timeout or flush:** in FILL, push `{len=asm_cnt, data}` with unused upper lanes zero, then go to EMPTY and clear the idle counter.
  - `flush` while in EMPTY has no effect.
- **din_valid and flush in the same edge:** the byte is included first, then the result is pushed with the updated length (1..4). Exactly one word is pushed.
- **Queue:** DEPTH entries, each 35 bits (`{len, data}`).
  - A pop occurs when `word_valid && word_ready`.
  - A push to a full queue is accepted if a pop happens in the same edge.
  - Otherwise the pushed word is discarded, `overflow` is set to 1, and `drop_cnt` is incremented (saturating).
  - The head entry is never corrupted by a dropped push.
- **Clearing `overflow` and `drop_cnt`:** reset only.

## Timing
- All outputs are registered or driven directly from registers. No combinational path from `din` or `din_valid` to any output.
- **Reset:** `rst_n` low asynchronously sets the following, and discards any partial word and queued words:
  - `word_out=0`, `word_len=0`, `word_valid=0`, `overflow=0`, `drop_cnt=0`
  - `asm_cnt=0`, idle counter 0, queue pointers 0
- **Word latency:** if the completing byte (or flush) is sampled at edge E, `word_valid` is high from E until the word is popped.
- **Timeout latency:** last byte sampled at edge E; with no further bytes, the push occurs at edge E+`TIMEOUT`.
- **Handshake:**
  - While `word_valid=1` and `word_ready=0`, `word_out`/`word_len` hold stable.
  - After a pop, the next entry appears in the same cycle the pop edge completes; otherwise `word_valid` drops.
- **Throughput:** one byte per cycle is accepted continuously; one word per cycle can be popped.

## Structure
- Shared package `arb_pkg`:
  - `BYTE_W=8`, `WORD_BYTES=4`, `LEN_W=3`
  - Packed struct `word_entry_t {len, data}`
  - FSM enum `{EMPTY, FILL}`
- Sub-module `word_queue`: a parameterised synchronous FIFO of `word_entry_t` with `full`, `empty`, and simultaneous push/pop.
- Top level: assembly, idle timer, drop accounting.

## Test plan
- **Full word:** bytes 87, 56, 9, 12 on 4 consecutive cycles, `word_ready=1` → one word `0x0C093857`, `word_len=4`, `word_valid` high for 1 cycle.
- **Timeout flush:** single byte 85, then idle, `TIMEOUT=8` → `word_out=0x00000055`, `word_len=1`, `word_valid` rising exactly 8 edges after the byte edge. No push occurs before that.
- **Flush with byte:** bytes 129, 51, then `flush=1` together with byte 7 → `0x00073381`, `word_len=3`; no second word follows.
- **Overflow:** `word_ready=0`, DEPTH=2, 12 bytes 1..12 →
  - Queue holds `0x04030201` and `0x08070605`.
  - Third word dropped: `overflow=1`, `drop_cnt=1`.
  - Raising `word_ready` pops the two words in order.
- **Reset mid-operation:** 2 bytes sent, `rst_n` pulsed low between edges → all outputs 0 immediately. Next bytes 0xAA, 0xBB, 0xCC, 0xDD yield `0xDDCCBBAA`, with no stale lanes.
